key_mode_sequencer: RTL and testbench

- Synchronous front end that drives the 2-bit MODE bus into the calculator top-level output multiplexer.
- Replaces direct KEY-to-MODE mapping with synchronised, debounced, edge-detected button handling.
- KEY[0] steps MODE forward through arithmetic→logical→comparison→magic; KEY[1] steps it backward.
- Emits a one-cycle strobe on every MODE change, plus debounced key levels for LED indication.

---
 rtl/key_mode_sequencer_if.sv | 22 ++
 rtl/key_mode_sequencer.sv | 92 +++++++++
 tb/tb_key_mode_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/key_mode_sequencer_if.sv
// Key/mode bundle between the DE10-Lite buttons and the calculator output mux.
// The sequencer owns MODE, MODE_CHANGE and KEY_PRESSED; the board side drives KEY.
interface key_mode_sequencer_if;
  logic [1:0] KEY;
  logic [1:0] MODE;
  logic       MODE_CHANGE;
  logic [1:0] KEY_PRESSED;

  modport master (
    output KEY,
    input  MODE,
    input  MODE_CHANGE,
    input  KEY_PRESSED
  );

  modport slave (
    input  KEY,
    output MODE,
    output MODE_CHANGE,
    output KEY_PRESSED
  );
endinterface

// File: rtl/key_mode_sequencer.sv
// Synchronises, debounces and edge-detects the two push buttons and steps the
// 2-bit calculator MODE forward (KEY[0]) or backward (KEY[1]) on each press.
module key_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input logic                  MAX10_CLK1_50,
  input logic                  RESET_N,
  key_mode_sequencer_if.slave  bus
);

  localparam int unsigned       NKEYS    = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0]                sync1;
  logic [NKEYS-1:0]                sync2;
  logic [NKEYS-1:0]                stable;
  logic [NKEYS-1:0]                stable_d;
  logic [NKEYS-1:0][CNT_WIDTH-1:0] cnt;
  logic [1:0]                      mode;
  logic                            mode_change;
  logic [NKEYS-1:0]                key_pressed;

  logic [NKEYS-1:0]                stable_nxt;
  logic [NKEYS-1:0][CNT_WIDTH-1:0] cnt_nxt;
  logic [NKEYS-1:0]                press_c;
  logic [1:0]                      mode_nxt;
  logic                            mode_change_nxt;

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Falling edge of the debounced (active-low) level is a press; coincident presses cancel.
  always_comb begin
    press_c         = stable_d & ~stable;
    mode_nxt        = mode;
    mode_change_nxt = 1'b0;
    case (press_c)
      2'b01: begin
        mode_nxt        = mode + 2'd1;
        mode_change_nxt = 1'b1;
      end
      2'b10: begin
        mode_nxt        = mode - 2'd1;
        mode_change_nxt = 1'b1;
      end
      default: begin
        mode_nxt        = mode;
        mode_change_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      sync1       <= '1;
      sync2       <= '1;
      stable      <= '1;
      stable_d    <= '1;
      cnt         <= '0;
      mode        <= '0;
      mode_change <= 1'b0;
      key_pressed <= '0;
    end else begin
      sync1       <= bus.KEY;
      sync2       <= sync1;
      stable      <= stable_nxt;
      stable_d    <= stable;
      cnt         <= cnt_nxt;
      mode        <= mode_nxt;
      mode_change <= mode_change_nxt;
      key_pressed <= ~stable;
    end
  end

  assign bus.MODE        = mode;
  assign bus.MODE_CHANGE = mode_change;
  assign bus.KEY_PRESSED = key_pressed;

endmodule

// File: tb/tb_key_mode_sequencer.sv
// Directed per-cycle vector bench for key_mode_sequencer with a 4-cycle debounce.
module tb_key_mode_sequencer;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 3;

  typedef struct {
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] mode;
    logic       chg;
    logic [1:0] pressed;
    string      tag;
  } vec_t;

  logic clk;
  logic RESET_N;
  key_mode_sequencer_if kif ();

  key_mode_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_WIDTH       (CW)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .RESET_N       (RESET_N),
    .bus           (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic [1:0] k, input logic [1:0] m,
                     input logic c, input logic [1:0] p, input int n, input string tag);
    vec_t v;
    v.rst_n = r; v.key = k; v.mode = m; v.chg = c; v.pressed = p; v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive inputs mid-cycle, check outputs just after the sampling edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    RESET_N = v.rst_n;
    kif.KEY = v.key;
    @(posedge clk);
    #1;
    applied++;
    if (kif.MODE !== v.mode || kif.MODE_CHANGE !== v.chg || kif.KEY_PRESSED !== v.pressed) begin
      miscompares++;
      $display("FAIL vec %0d [%s]: MODE=%0d MODE_CHANGE=%0b KEY_PRESSED=%b, expected MODE=%0d MODE_CHANGE=%0b KEY_PRESSED=%b",
               idx, v.tag, kif.MODE, kif.MODE_CHANGE, kif.KEY_PRESSED, v.mode, v.chg, v.pressed);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    kif.KEY = 2'b11;

    // Reset, then idle.
    add(0, 2'b11, 0, 0, 2'b00, 3, "reset");
    add(1, 2'b11, 0, 0, 2'b00, 2, "idle");

    // Held KEY[0]: single step at edge 7, no repeat, then debounced release.
    add(1, 2'b10, 0, 0, 2'b00, 6, "k0 wait");
    add(1, 2'b10, 1, 1, 2'b01, 1, "k0 step");
    add(1, 2'b10, 1, 0, 2'b01, 5, "k0 hold");
    add(1, 2'b11, 1, 0, 2'b01, 6, "k0 rel wait");
    add(1, 2'b11, 1, 0, 2'b00, 3, "k0 released");

    // Re-reset, then four KEY[0] presses walk 1,2,3,0.
    add(0, 2'b11, 0, 0, 2'b00, 2, "rereset");
    for (int j = 0; j < 4; j++) begin
      add(1, 2'b10, 2'(j),     0, 2'b00, 6, "fwd wait");
      add(1, 2'b10, 2'(j + 1), 1, 2'b01, 1, "fwd step");
      add(1, 2'b11, 2'(j + 1), 0, 2'b01, 6, "fwd rel");
      add(1, 2'b11, 2'(j + 1), 0, 2'b00, 1, "fwd idle");
    end

    // KEY[1] from 0 wraps down to 3.
    add(1, 2'b01, 0, 0, 2'b00, 6, "back wait");
    add(1, 2'b01, 3, 1, 2'b10, 1, "back wrap");
    add(1, 2'b11, 3, 0, 2'b10, 6, "back rel");
    add(1, 2'b11, 3, 0, 2'b00, 2, "back idle");

    // Bounce: 3 low / 1 high never reaches the 4-cycle threshold.
    for (int j = 0; j < 5; j++) begin
      add(1, 2'b10, 3, 0, 2'b00, 3, "bounce lo");
      add(1, 2'b11, 3, 0, 2'b00, 1, "bounce hi");
    end
    add(1, 2'b11, 3, 0, 2'b00, 6, "bounce settle");

    // Both keys on the same edge: levels shown, mode untouched, no strobe.
    add(1, 2'b00, 3, 0, 2'b00, 6, "both wait");
    add(1, 2'b00, 3, 0, 2'b11, 4, "both held");
    add(1, 2'b11, 3, 0, 2'b11, 6, "both rel");
    add(1, 2'b11, 3, 0, 2'b00, 2, "both idle");

    // Staggered presses are independent: KEY[0] first, KEY[1] two cycles later.
    add(1, 2'b10, 3, 0, 2'b00, 2, "stag k0");
    add(1, 2'b00, 3, 0, 2'b00, 4, "stag both");
    add(1, 2'b00, 0, 1, 2'b01, 1, "stag up");
    add(1, 2'b00, 0, 0, 2'b01, 1, "stag gap");
    add(1, 2'b00, 3, 1, 2'b11, 1, "stag down");
    add(1, 2'b00, 3, 0, 2'b11, 2, "stag held");
    add(1, 2'b11, 3, 0, 2'b11, 6, "stag rel");
    add(1, 2'b11, 3, 0, 2'b00, 2, "stag idle");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-debounce with KEY[1] held through release: counted once afterwards.
    begin
      vec_t v;
      int   base;
      base = vecs.size();
      v.key = 2'b01; v.rst_n = 1'b1; v.chg = 1'b0; v.pressed = 2'b00; v.mode = 2'd3;
      v.tag = "rst pre";
      for (int e = 1; e <= 4; e++) apply(v, base++);
      v.rst_n = 1'b0; v.mode = 2'd0; v.tag = "rst mid";
      for (int e = 0; e < 2; e++) apply(v, base++);
      v.rst_n = 1'b1; v.tag = "rst post wait";
      for (int e = 1; e <= 6; e++) apply(v, base++);
      v.mode = 2'd3; v.chg = 1'b1; v.pressed = 2'b10; v.tag = "rst post step";
      apply(v, base++);
      v.chg = 1'b0; v.tag = "rst post hold";
      for (int e = 0; e < 4; e++) apply(v, base++);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
